urv_prefetch: RTL and testbench

URV_PREFETCH -- requirements
Module: urv_prefetch

---
 rtl/urv_prefetch.sv | 111 +++++++++++
 tb/tb_urv_prefetch.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/urv_prefetch.sv
// Instruction prefetch unit: issues sequential fetches under a credit limit and
// buffers in-order responses in a small {pc, ir} queue that decode drains.
module urv_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    output logic                     im_req_o,
    output logic [31:0]              im_addr_o,
    input  logic                     im_gnt_i,
    input  logic                     im_valid_i,
    input  logic [31:0]              im_data_i,
    output logic                     f_valid_o,
    output logic [31:0]              f_ir_o,
    output logic [31:0]              f_pc_o,
    input  logic                     f_ready_i,
    input  logic                     x_bra_i,
    input  logic [31:0]              x_pc_bra_i,
    output logic [$clog2(DEPTH):0]   fq_level_o
);

    localparam int          AW          = $clog2(DEPTH);
    localparam int          OW          = $clog2(MAX_OUT) + 1;
    localparam int          CW          = AW + OW + 1;
    localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

    logic [31:0]   req_pc;
    logic [31:0]   resp_pc;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] drop_cnt;
    logic [AW:0]   count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   fifo_pc [DEPTH];
    logic [31:0]   fifo_ir [DEPTH];

    logic [CW-1:0] credit;
    logic          accept;
    logic          resp;
    logic          push;
    logic          drop;
    logic          pop;
    logic [31:0]   bra_pc;

    // Slots already promised: queued words plus live requests that will still land.
    always_comb begin
        credit = CW'(count) + CW'(outstanding) - CW'(drop_cnt);
    end

    assign bra_pc    = {x_pc_bra_i[31:2], 2'b00};
    assign im_req_o  = rst_n_i & ~x_bra_i & (outstanding < OW'(MAX_OUT))
                     & (credit < CW'(DEPTH));
    assign im_addr_o = req_pc;

    assign accept = im_req_o & im_gnt_i;
    assign resp   = im_valid_i & (outstanding != '0);
    assign push   = resp & ~x_bra_i & (drop_cnt == '0);
    assign drop   = resp & ~x_bra_i & (drop_cnt != '0);
    assign pop    = f_valid_o & f_ready_i & ~x_bra_i;

    assign f_valid_o  = (count != '0);
    assign f_pc_o     = f_valid_o ? fifo_pc[rd_ptr] : 32'h0;
    assign f_ir_o     = f_valid_o ? fifo_ir[rd_ptr] : 32'h0;
    assign fq_level_o = count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            req_pc      <= RESET_PC_AL;
            resp_pc     <= RESET_PC_AL;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding + OW'(accept) - OW'(resp);
            if (x_bra_i) begin
                // Everything still in flight belongs to the old stream.
                req_pc   <= bra_pc;
                resp_pc  <= bra_pc;
                drop_cnt <= outstanding - OW'(resp);
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (accept) req_pc <= req_pc + 32'd4;
                if (drop) drop_cnt <= drop_cnt - OW'(1);
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + AW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end

    // NOTE: queue storage is deliberately not reset; the head outputs are
    // masked by f_valid_o, so stale contents are never observable.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_pc[wr_ptr] <= resp_pc;
            fifo_ir[wr_ptr] <= im_data_i;
        end
    end

endmodule

// File: tb/tb_urv_prefetch.sv
// Self-checking bench for urv_prefetch: randomized memory/decode/redirect
// stimulus against a stream-level model of the expected fetch sequence.
module tb_urv_prefetch;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;

    logic        clk_i;
    logic        rst_n_i;
    logic        im_req_o;
    logic [31:0] im_addr_o;
    logic        im_gnt_i;
    logic        im_valid_i;
    logic [31:0] im_data_i;
    logic        f_valid_o;
    logic [31:0] f_ir_o;
    logic [31:0] f_pc_o;
    logic        f_ready_i;
    logic        x_bra_i;
    logic [31:0] x_pc_bra_i;
    logic [2:0]  fq_level_o;

    urv_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .im_req_o   (im_req_o),
        .im_addr_o  (im_addr_o),
        .im_gnt_i   (im_gnt_i),
        .im_valid_i (im_valid_i),
        .im_data_i  (im_data_i),
        .f_valid_o  (f_valid_o),
        .f_ir_o     (f_ir_o),
        .f_pc_o     (f_pc_o),
        .f_ready_i  (f_ready_i),
        .x_bra_i    (x_bra_i),
        .x_pc_bra_i (x_pc_bra_i),
        .fq_level_o (fq_level_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] acc_log[$];
    int          cyc;
    int          n_checks;
    int          n_fail;

    int          p_gnt, p_ready, p_bra, lat_min, lat_max;
    bit          force_bra;
    logic [31:0] force_tgt;
    bit          stray;

    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    bit          after_bra;
    bit          hold_pend;
    logic [31:0] hold_pc;
    logic [31:0] hold_ir;
    int          pop_cnt;
    logic [31:0] last_pop_pc;
    logic        s_req;
    logic [2:0]  s_level;

    // Memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle; entered and left at a falling edge.
    task automatic step();
        bit          from_mem;
        logic        acc;
        logic        pop;
        logic [31:0] acc_addr;
        logic        s_valid;
        logic        s_ready;
        logic        s_bra;
        logic [31:0] s_tgt;

        im_gnt_i   = (int'($urandom_range(99)) < p_gnt);
        f_ready_i  = (int'($urandom_range(99)) < p_ready);
        x_bra_i    = force_bra || (int'($urandom_range(99)) < p_bra);
        x_pc_bra_i = force_bra ? force_tgt : $urandom;
        force_bra  = 1'b0;
        from_mem   = (mq.size() > 0) && (mq[0].due <= cyc);
        if (from_mem) begin
            im_valid_i = 1'b1;
            im_data_i  = mem_fn(mq[0].addr);
        end else if (stray) begin
            im_valid_i = 1'b1;
            im_data_i  = $urandom;
        end else begin
            im_valid_i = 1'b0;
            im_data_i  = $urandom;
        end
        stray = 1'b0;
        #1;

        s_req   = im_req_o;
        s_level = fq_level_o;
        s_valid = f_valid_o;
        s_ready = f_ready_i;
        s_bra   = x_bra_i;
        s_tgt   = x_pc_bra_i;

        if (after_bra) begin
            n_checks++;
            if (f_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL valid_after_branch got=%b want=0", f_valid_o);
            end
        end
        if (hold_pend) begin
            n_checks++;
            if (f_valid_o !== 1'b1 || f_pc_o !== hold_pc || f_ir_o !== hold_ir) begin
                n_fail++;
                $display("FAIL head_stable got v=%b pc=%h ir=%h want v=1 pc=%h ir=%h",
                         f_valid_o, f_pc_o, f_ir_o, hold_pc, hold_ir);
            end
        end
        n_checks++;
        if ($isunknown(fq_level_o) || int'(fq_level_o) > DEPTH ||
            ((fq_level_o != 3'd0) != f_valid_o)) begin
            n_fail++;
            $display("FAIL level_consistent got level=%0d valid=%b want level<=%0d and valid==(level!=0)",
                     fq_level_o, f_valid_o, DEPTH);
        end
        n_checks++;
        if (mq.size() > MAX_OUT) begin
            n_fail++;
            $display("FAIL outstanding_bound got=%0d want<=%0d", mq.size(), MAX_OUT);
        end
        if (x_bra_i) begin
            n_checks++;
            if (im_req_o !== 1'b0) begin
                n_fail++;
                $display("FAIL req_during_branch got=%b want=0", im_req_o);
            end
        end

        acc      = im_req_o & im_gnt_i;
        acc_addr = im_addr_o;
        if (acc) begin
            n_checks++;
            if (im_addr_o !== exp_req) begin
                n_fail++;
                $display("FAIL fetch_addr got=%h want=%h", im_addr_o, exp_req);
            end
            acc_log.push_back(im_addr_o);
            exp_req = exp_req + 32'd4;
        end

        pop = f_valid_o & f_ready_i & ~x_bra_i;
        if (pop) begin
            n_checks++;
            if (f_pc_o !== exp_pc || f_ir_o !== mem_fn(exp_pc)) begin
                n_fail++;
                $display("FAIL fetch_stream got pc=%h ir=%h want pc=%h ir=%h",
                         f_pc_o, f_ir_o, exp_pc, mem_fn(exp_pc));
            end
            last_pop_pc = f_pc_o;
            pop_cnt++;
            exp_pc = exp_pc + 32'd4;
        end
        hold_pc = f_pc_o;
        hold_ir = f_ir_o;

        @(posedge clk_i);
        if (acc) mq.push_back('{addr: acc_addr,
                               due: cyc + 1 + int'($urandom_range(lat_max, lat_min))});
        if (from_mem) mq.delete(0);
        if (s_bra) begin
            exp_pc  = {s_tgt[31:2], 2'b00};
            exp_req = {s_tgt[31:2], 2'b00};
            acc_log.delete();
        end
        after_bra = s_bra;
        hold_pend = s_valid & ~s_ready & ~s_bra;
        cyc++;
        @(negedge clk_i);
    endtask

    // Asynchronous reset a few ns into the low phase; returns just after a falling edge.
    task automatic do_reset();
        #3;
        rst_n_i = 1'b0;
        #1;
        n_checks++;
        if (f_valid_o !== 1'b0 || im_req_o !== 1'b0 || fq_level_o !== 3'd0 ||
            f_pc_o !== 32'h0 || f_ir_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b req=%b lvl=%0d pc=%h ir=%h want all zero",
                     f_valid_o, im_req_o, fq_level_o, f_pc_o, f_ir_o);
        end
        im_gnt_i   = 1'b0;
        im_valid_i = 1'b0;
        x_bra_i    = 1'b0;
        f_ready_i  = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        mq.delete();
        acc_log.delete();
        exp_pc    = RESET_PC;
        exp_req   = RESET_PC;
        after_bra = 1'b0;
        hold_pend = 1'b0;
        #1;
        n_checks++;
        if (im_req_o !== 1'b1 || im_addr_o !== RESET_PC) begin
            n_fail++;
            $display("FAIL first_request got req=%b addr=%h want req=1 addr=%h",
                     im_req_o, im_addr_o, RESET_PC);
        end
    endtask

    task automatic set_knobs(input int g, input int r, input int b, input int lmin, input int lmax);
        p_gnt   = g;
        p_ready = r;
        p_bra   = b;
        lat_min = lmin;
        lat_max = lmax;
    endtask

    task automatic test_reset();
        set_knobs(100, 100, 0, 0, 0);
        do_reset();
    endtask

    task automatic test_stream();
        int n0;
        do_reset();
        set_knobs(100, 100, 0, 0, 0);
        repeat (4) step();
        n0 = pop_cnt;
        repeat (20) step();
        n_checks++;
        if (pop_cnt - n0 != 20) begin
            n_fail++;
            $display("FAIL stream_rate got=%0d want=20 words in 20 cycles", pop_cnt - n0);
        end
    endtask

    task automatic test_backpressure();
        int n0;
        do_reset();
        set_knobs(100, 0, 0, 0, 0);
        repeat (10) step();
        n_checks++;
        if (s_level !== 3'(DEPTH) || s_req !== 1'b0) begin
            n_fail++;
            $display("FAIL saturate got level=%0d req=%b want level=%0d req=0", s_level, s_req, DEPTH);
        end
        n0 = pop_cnt;
        set_knobs(100, 100, 0, 0, 0);
        repeat (20) step();
        n_checks++;
        if (pop_cnt - n0 < DEPTH) begin
            n_fail++;
            $display("FAIL drain got=%0d want>=%0d", pop_cnt - n0, DEPTH);
        end
    endtask

    task automatic test_branch();
        int n0;
        do_reset();
        set_knobs(100, 100, 0, 4, 4);
        repeat (2) step();
        n_checks++;
        if (mq.size() != 2) begin
            n_fail++;
            $display("FAIL bra_outstanding got=%0d want=2", mq.size());
        end
        force_bra = 1'b1;
        force_tgt = 32'h100;
        n0 = pop_cnt;
        step();
        for (int i = 0; i < 60 && pop_cnt == n0; i++) step();
        n_checks++;
        if (pop_cnt == n0 || last_pop_pc !== 32'h100) begin
            n_fail++;
            $display("FAIL bra_target got pops=%0d pc=%h want pc=00000100", pop_cnt - n0, last_pop_pc);
        end
        repeat (10) step();
    endtask

    task automatic test_wrap();
        do_reset();
        set_knobs(100, 100, 0, 0, 0);
        force_bra = 1'b1;
        force_tgt = 32'hFFFF_FFFE;
        step();
        for (int i = 0; i < 20 && acc_log.size() < 2; i++) step();
        n_checks++;
        if (acc_log.size() < 2) begin
            n_fail++;
            $display("FAIL wrap_fetch got %0d requests want 2", acc_log.size());
        end else if (acc_log[0] !== 32'hFFFF_FFFC || acc_log[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_fetch got %h,%h want fffffffc,00000000", acc_log[0], acc_log[1]);
        end
        repeat (10) step();
    endtask

    task automatic test_random();
        int n0;
        do_reset();
        set_knobs(70, 60, 3, 0, 5);
        n0 = pop_cnt;
        repeat (3000) step();
        n_checks++;
        if (pop_cnt - n0 < 200) begin
            n_fail++;
            $display("FAIL random_progress got=%0d want>=200", pop_cnt - n0);
        end
    endtask

    task automatic test_async_reset();
        int n0;
        set_knobs(90, 40, 0, 0, 2);
        repeat (50) step();
        do_reset();
        stray = 1'b1;
        set_knobs(100, 100, 0, 0, 1);
        n0 = pop_cnt;
        step();
        for (int i = 0; i < 20 && pop_cnt == n0; i++) step();
        n_checks++;
        if (pop_cnt == n0 || last_pop_pc !== RESET_PC) begin
            n_fail++;
            $display("FAIL restart_pc got pops=%0d pc=%h want pc=%h", pop_cnt - n0, last_pop_pc, RESET_PC);
        end
        repeat (20) step();
    endtask

    initial begin
        rst_n_i    = 1'b0;
        im_gnt_i   = 1'b0;
        im_valid_i = 1'b0;
        im_data_i  = 32'h0;
        f_ready_i  = 1'b0;
        x_bra_i    = 1'b0;
        x_pc_bra_i = 32'h0;
        force_bra  = 1'b0;
        force_tgt  = 32'h0;
        stray      = 1'b0;
        cyc        = 0;
        n_checks   = 0;
        n_fail     = 0;
        pop_cnt    = 0;
        last_pop_pc = 32'h0;
        after_bra  = 1'b0;
        hold_pend  = 1'b0;
        exp_pc     = RESET_PC;
        exp_req    = RESET_PC;

        test_reset();
        test_stream();
        test_backpressure();
        test_branch();
        test_wrap();
        test_random();
        test_async_reset();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
